mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one sram-like memory port between the instruction-fetch path and the data path (the MEM-stage load/store traffic) of the pipelined CPU. It grants one request per cycle and holds the grant until the address is accepted. It records the owner of every accepted request in an in-order owner queue and routes each `data_ok`/`rdata` response back to the requester that issued it. The block sits between the pipeline's IF/EXE–MEM stages and the single memory-side bridge.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/owner_fifo.sv | 70 +++++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: owner encodings, the fixed
// instruction-fetch access size and the lock FSM states.
package mem_port_arbiter_pkg;

    // Which requester issued a memory request.
    typedef enum logic {
        OwnerInst = 1'b0,
        OwnerData = 1'b1
    } owner_e;

    // Instruction fetches are always full-word reads.
    localparam logic [1:0] SizeWord = 2'd2;

    typedef enum logic [0:0] {
        StUnlocked = 1'b0,
        StLocked   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/owner_fifo.sv
// In-order queue of 1-bit owner tags, one per accepted-but-unanswered request.
// Depth must be a power of two so the pointers wrap naturally.
module owner_fifo #(
    parameter int unsigned Depth = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push_i,
    input  logic pop_i,
    input  logic data_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Depth);

    logic [Depth-1:0] mem_q, mem_d;
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Next-state: pops need a non-empty queue; a push into a full queue is only
    // legal when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop_i && (cnt_q != '0);
        do_push = push_i && ((cnt_q != CntMax) || do_pop);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (do_push) begin
            mem_d[wptr_q] = data_i;
            wptr_d        = wptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Status and head outputs.
    always_comb begin
        full_o  = (cnt_q == CntMax);
        empty_o = (cnt_q == '0);
        head_o  = mem_q[rptr_q];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sram-like memory port between instruction fetch and data access.
// Holds the grant until the address is accepted and routes in-order responses
// back to their issuer via an owner queue.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants when both requesters are
// active; otherwise data has fixed priority over instruction fetch.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    lock_state_e lock_q, lock_d;
    owner_e      lock_owner_q, lock_owner_d;
    owner_e      sel_owner, both_pick, head_owner;
    logic        sel_valid, sel_req, handshake, pop;
    logic        fifo_full, fifo_empty, fifo_head, queue_full;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_q, last_d;

    // Track who won the most recent accepted handshake.
    always_comb begin
        last_d = last_q;
        if (handshake) begin
            last_d = sel_owner;
        end
        both_pick = (last_q == OwnerInst) ? OwnerData : OwnerInst;
    end

    // Last-winner register; resets to INST so DATA wins the first contest.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_q <= OwnerInst;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: data wins any contest.
    always_comb begin
        both_pick = OwnerData;
    end
`endif

    // Owner selection: a held lock overrides arbitration.
    always_comb begin
        sel_valid = 1'b0;
        sel_owner = OwnerInst;
        if (lock_q == StLocked) begin
            sel_valid = 1'b1;
            sel_owner = lock_owner_q;
        end else if (inst_req && data_req) begin
            sel_valid = 1'b1;
            sel_owner = both_pick;
        end else if (data_req) begin
            sel_valid = 1'b1;
            sel_owner = OwnerData;
        end else if (inst_req) begin
            sel_valid = 1'b1;
            sel_owner = OwnerInst;
        end
    end

    // Request mux and handshake; a response popping this cycle frees a slot.
    always_comb begin
        queue_full   = fifo_full && !m_data_ok;
        sel_req      = (sel_owner == OwnerData) ? data_req : inst_req;
        m_req        = sel_valid && sel_req && !queue_full;
        handshake    = m_req && m_addr_ok;
        inst_addr_ok = handshake && (sel_owner == OwnerInst);
        data_addr_ok = handshake && (sel_owner == OwnerData);
        m_wr         = 1'b0;
        m_size       = '0;
        m_wstrb      = '0;
        m_addr       = '0;
        m_wdata      = '0;
        if (sel_valid && (sel_owner == OwnerData)) begin
            m_wr    = data_wr;
            m_size  = data_size;
            m_wstrb = data_wstrb;
            m_addr  = data_addr;
            m_wdata = data_wdata;
        end else if (sel_valid) begin
            m_size = SizeWord;
            m_addr = inst_addr;
        end
    end

    // Lock FSM next state: lock on a stalled request, release on acceptance.
    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        case (lock_q)
            StUnlocked: begin
                if (m_req && !m_addr_ok) begin
                    lock_d       = StLocked;
                    lock_owner_d = sel_owner;
                end
            end
            StLocked: begin
                if (handshake) begin
                    lock_d = StUnlocked;
                end
            end
            default: lock_d = StUnlocked;
        endcase
    end

    // Lock state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_q       <= StUnlocked;
            lock_owner_q <= OwnerInst;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
        end
    end

    owner_fifo #(
        .Depth (OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (handshake),
        .pop_i   (pop),
        .data_i  (sel_owner),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // Response routing; responses with nothing outstanding are dropped.
    always_comb begin
        pop          = m_data_ok && !fifo_empty;
        head_owner   = owner_e'(fifo_head);
        inst_data_ok = pop && (head_owner == OwnerInst);
        data_data_ok = pop && (head_owner == OwnerData);
        inst_rdata   = m_data_ok ? m_rdata : '0;
        data_rdata   = m_data_ok ? m_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-by-cycle vector table plus
// hand-written lock, reset and contention sequences.
module tb_mem_port_arbiter;

    localparam logic [31:0] IA = 32'h0000_1000;
    localparam logic [31:0] DA = 32'h0000_2040;
    localparam logic [31:0] WD = 32'hCAFE_F00D;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, data_req, data_wr, m_addr_ok, m_data_ok;
    logic [31:0] inst_addr, data_addr, data_wdata, m_rdata;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .OUTSTANDING (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_size       (m_size),
        .m_wstrb      (m_wstrb),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .m_rdata      (m_rdata)
    );

    typedef struct {
        logic        ireq, dreq, dwr, aok, dok;
        logic [31:0] rdata;
        logic        e_mreq, e_iaok, e_daok, e_idok, e_ddok;
        logic [31:0] e_addr;
        logic        e_wr;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, then let it settle.
    task automatic set_in(input logic ireq, input logic dreq, input logic dwr,
                          input logic aok, input logic dok, input logic [31:0] rd);
        @(negedge clk);
        inst_req  = ireq;
        data_req  = dreq;
        data_wr   = dwr;
        m_addr_ok = aok;
        m_data_ok = dok;
        m_rdata   = rd;
        #1;
    endtask

    initial begin
        owner_check_t: begin end
        resetn     = 1'b0;
        inst_req   = 1'b0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        m_addr_ok  = 1'b0;
        m_data_ok  = 1'b0;
        m_rdata    = '0;
        inst_addr  = IA;
        data_addr  = DA;
        data_wdata = WD;
        data_size  = 2'd0;
        data_wstrb = 4'b0001;

        //          ireq dreq dwr aok dok rdata         mreq iaok daok idok ddok addr wr
        vecs[0]  = '{0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 32'h0, 0};
        vecs[1]  = '{1, 1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, DA,    0};
        vecs[2]  = '{0, 0, 0, 0, 1, 32'h1234_5678,  0, 0, 0, 0, 1, 32'h0, 0};
        vecs[3]  = '{1, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, IA,    0};
        vecs[4]  = '{1, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, IA,    0};
        vecs[5]  = '{0, 1, 1, 1, 0, 32'h0,          0, 0, 0, 0, 0, DA,    1};
        vecs[6]  = '{0, 1, 1, 1, 1, 32'hAAAA_0001,  1, 0, 1, 1, 0, DA,    1};
        vecs[7]  = '{0, 1, 1, 1, 0, 32'h0,          0, 0, 0, 0, 0, DA,    1};
        vecs[8]  = '{0, 0, 0, 0, 1, 32'hBBBB_0002,  0, 0, 0, 1, 0, 32'h0, 0};
        vecs[9]  = '{0, 0, 0, 0, 1, 32'hCCCC_0003,  0, 0, 0, 0, 1, 32'h0, 0};
        vecs[10] = '{0, 0, 0, 0, 1, 32'hDEAD_BEEF,  0, 0, 0, 0, 0, 32'h0, 0};
        vecs[11] = '{1, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, IA,    0};
        vecs[12] = '{0, 1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, DA,    0};
        vecs[13] = '{0, 0, 0, 0, 1, 32'h1111_0001,  0, 0, 0, 1, 0, 32'h0, 0};
        vecs[14] = '{1, 0, 0, 1, 1, 32'h2222_0002,  1, 1, 0, 0, 1, IA,    0};
        vecs[15] = '{0, 0, 0, 0, 1, 32'h3333_0003,  0, 0, 0, 1, 0, 32'h0, 0};

        repeat (2) @(negedge clk);
        #1;
        check("reset m_req", m_req, 0);
        check("reset m_addr", m_addr, 0);
        check("reset inst_data_ok", inst_data_ok, 0);
        check("reset data_data_ok", data_data_ok, 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            set_in(vecs[i].ireq, vecs[i].dreq, vecs[i].dwr, vecs[i].aok, vecs[i].dok,
                   vecs[i].rdata);
            check($sformatf("v%0d m_req", i), m_req, vecs[i].e_mreq);
            check($sformatf("v%0d inst_addr_ok", i), inst_addr_ok, vecs[i].e_iaok);
            check($sformatf("v%0d data_addr_ok", i), data_addr_ok, vecs[i].e_daok);
            check($sformatf("v%0d inst_data_ok", i), inst_data_ok, vecs[i].e_idok);
            check($sformatf("v%0d data_data_ok", i), data_data_ok, vecs[i].e_ddok);
            check($sformatf("v%0d m_addr", i), m_addr, vecs[i].e_addr);
            check($sformatf("v%0d m_wr", i), m_wr, vecs[i].e_wr);
            if (vecs[i].e_idok) check($sformatf("v%0d inst_rdata", i), inst_rdata, vecs[i].rdata);
            if (vecs[i].e_ddok) check($sformatf("v%0d data_rdata", i), data_rdata, vecs[i].rdata);
        end

        // Lock: instruction request stalls 3 cycles, data arrives in cycle 2.
        set_in(1, 0, 0, 0, 0, 0);
        check("lock c1 m_req", m_req, 1);
        check("lock c1 m_addr", m_addr, IA);
        check("lock c1 inst_addr_ok", inst_addr_ok, 0);
        set_in(1, 1, 0, 0, 0, 0);
        check("lock c2 m_addr", m_addr, IA);
        check("lock c2 data_addr_ok", data_addr_ok, 0);
        check("lock c2 m_size", m_size, 2);
        check("lock c2 m_wstrb", m_wstrb, 0);
        set_in(1, 1, 0, 0, 0, 0);
        check("lock c3 m_addr", m_addr, IA);
        set_in(1, 1, 0, 1, 0, 0);
        check("lock c4 inst_addr_ok", inst_addr_ok, 1);
        check("lock c4 data_addr_ok", data_addr_ok, 0);
        check("lock c4 m_addr", m_addr, IA);
        set_in(0, 1, 0, 1, 0, 0);
        check("lock c5 data_addr_ok", data_addr_ok, 1);
        check("lock c5 m_addr", m_addr, DA);
        check("lock c5 m_size", m_size, 0);
        check("lock c5 m_wstrb", m_wstrb, 4'b0001);
        check("lock c5 m_wdata", m_wdata, WD);
        set_in(0, 0, 0, 0, 1, 32'h0000_00A1);
        check("lock drain1 inst_data_ok", inst_data_ok, 1);
        check("lock drain1 data_data_ok", data_data_ok, 0);
        set_in(0, 0, 0, 0, 1, 32'h0000_00A2);
        check("lock drain2 data_data_ok", data_data_ok, 1);
        check("lock drain2 inst_data_ok", inst_data_ok, 0);

        // Reset mid-transaction: one owner outstanding plus a held data lock.
        set_in(1, 0, 0, 1, 0, 0);
        set_in(0, 1, 1, 0, 0, 0);
        check("rst pre m_addr", m_addr, DA);
        @(negedge clk);
        resetn   = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        set_in(0, 0, 0, 0, 1, 32'h5555_5555);
        check("rst late inst_data_ok", inst_data_ok, 0);
        check("rst late data_data_ok", data_data_ok, 0);
        set_in(1, 0, 0, 0, 0, 0);
        check("rst unlocked m_addr", m_addr, IA);
        check("rst unlocked m_req", m_req, 1);
        set_in(1, 0, 0, 1, 0, 0);
        check("rst push1 inst_addr_ok", inst_addr_ok, 1);
        set_in(1, 0, 0, 1, 0, 0);
        check("rst push2 inst_addr_ok", inst_addr_ok, 1);
        set_in(1, 0, 0, 1, 0, 0);
        check("rst full m_req", m_req, 0);
        check("rst full inst_addr_ok", inst_addr_ok, 0);
        set_in(0, 0, 0, 0, 1, 0);
        check("rst drain1 inst_data_ok", inst_data_ok, 1);
        set_in(0, 0, 0, 0, 1, 0);
        check("rst drain2 inst_data_ok", inst_data_ok, 1);

        // Continuous contention with a response every cycle after the first.
        begin
            logic prev_data;
            logic exp_data;
            prev_data = 1'b0;
            for (int k = 0; k < 4; k++) begin
                exp_data = RrEn ? (k % 2 == 0) : 1'b1;
                set_in(1, 1, 0, 1, (k > 0), 32'h0000_0100 + k);
                check($sformatf("rr%0d data_addr_ok", k), data_addr_ok, exp_data);
                check($sformatf("rr%0d inst_addr_ok", k), inst_addr_ok, !exp_data);
                check($sformatf("rr%0d data_data_ok", k), data_data_ok, (k > 0) && prev_data);
                check($sformatf("rr%0d inst_data_ok", k), inst_data_ok, (k > 0) && !prev_data);
                prev_data = exp_data;
            end
            set_in(0, 0, 0, 0, 1, 0);
            check("rr drain data_data_ok", data_data_ok, prev_data);
            check("rr drain inst_data_ok", inst_data_ok, !prev_data);
            set_in(0, 0, 0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
